// File: rtl/hazard_ctrl_pipe_if.sv
// D-stage hazard interface: decoder-side requests and the hazard unit's
// stall, forwarding, per-slot visibility and stall counter.
interface hazard_ctrl_pipe_if #(
    parameter int STAGES = 3,
    parameter int RW     = 5,
    parameter int TW     = 2,
    parameter int FW     = 2,
    parameter int CW     = 16
);
    logic                 d_valid;
    logic [RW-1:0]        d_rs;
    logic [RW-1:0]        d_rt;
    logic                 d_read_rs;
    logic                 d_read_rt;
    logic [TW-1:0]        d_tuse_rs;
    logic [TW-1:0]        d_tuse_rt;
    logic [RW-1:0]        d_a3;
    logic [TW-1:0]        d_tnew;
    logic                 d_is_mdft;
    logic                 d_md_start;
    logic                 mdu_busy;
    logic                 flush;
    logic                 stall;
    logic [FW-1:0]        fwd_sel_rs;
    logic [FW-1:0]        fwd_sel_rt;
    logic [STAGES*RW-1:0] stage_a3;
    logic [STAGES*TW-1:0] stage_tnew;
    logic [CW-1:0]        stall_cnt;

    modport master (
        output d_valid, d_rs, d_rt, d_read_rs, d_read_rt, d_tuse_rs, d_tuse_rt,
               d_a3, d_tnew, d_is_mdft, d_md_start, mdu_busy, flush,
        input  stall, fwd_sel_rs, fwd_sel_rt, stage_a3, stage_tnew, stall_cnt
    );

    modport slave (
        input  d_valid, d_rs, d_rt, d_read_rs, d_read_rt, d_tuse_rs, d_tuse_rt,
               d_a3, d_tnew, d_is_mdft, d_md_start, mdu_busy, flush,
        output stall, fwd_sel_rs, fwd_sel_rt, stage_a3, stage_tnew, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// Control-side hazard unit after the decoder. Tracks destination register and
// remaining Tnew of every instruction in the post-decode slots (slot 0 = E),
// and derives the D-stage stall, D-stage forward selects, the MDU structural
// stall and a saturating stall-cycle counter.
module hazard_ctrl_pipe #(
    parameter int STAGES = 3,
    parameter int RW     = 5,
    parameter int TW     = 2,
    parameter int FW     = 2,
    parameter int CW     = 16
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_pipe_if.slave bus
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    // Tnew counts down once per stage and parks at zero (result available).
    function automatic logic [TW-1:0] tnew_dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TW'(1);
    endfunction

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
        return (c == CNT_MAX) ? c : c + CW'(1);
    endfunction

    logic [STAGES-1:0]         valid_q, valid_d;
    logic [STAGES-1:0][RW-1:0] a3_q, a3_d;
    logic [STAGES-1:0][TW-1:0] tnew_q, tnew_d;
    logic                      md_q, md_d;
    logic [CW-1:0]             cnt_q, cnt_d;

    logic          hit_rs, hit_rt;
    logic [TW-1:0] tnew_rs, tnew_rt;
    logic [FW-1:0] fwd_rs, fwd_rt;
    logic          stall_rs, stall_rt, stall_md, stall;

    // Youngest-match search: walk oldest to youngest so the lowest slot wins.
    always_comb begin
        hit_rs  = 1'b0;
        hit_rt  = 1'b0;
        tnew_rs = '0;
        tnew_rt = '0;
        fwd_rs  = '0;
        fwd_rt  = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            if (valid_q[k] && a3_q[k] != '0 && a3_q[k] == bus.d_rs && bus.d_read_rs) begin
                hit_rs  = 1'b1;
                tnew_rs = tnew_q[k];
                fwd_rs  = FW'(k + 1);
            end
            if (valid_q[k] && a3_q[k] != '0 && a3_q[k] == bus.d_rt && bus.d_read_rt) begin
                hit_rt  = 1'b1;
                tnew_rt = tnew_q[k];
                fwd_rt  = FW'(k + 1);
            end
        end
    end

    // Stall sources: data not ready in time for Tuse, or MDU still occupied.
    always_comb begin
        stall_rs = bus.d_valid && hit_rs && (tnew_rs > bus.d_tuse_rs);
        stall_rt = bus.d_valid && hit_rt && (tnew_rt > bus.d_tuse_rt);
        stall_md = bus.d_valid && bus.d_is_mdft && (bus.mdu_busy || (valid_q[0] && md_q));
        stall    = stall_rs || stall_rt || stall_md;
    end

    // Slot advance, slot-0 load (bubble on stall), flush and counter update.
    always_comb begin
        valid_d = '0;
        a3_d    = '0;
        tnew_d  = '0;
        md_d    = 1'b0;
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            a3_d[k]    = a3_q[k-1];
            tnew_d[k]  = tnew_dec(tnew_q[k-1]);
        end
        if (bus.d_valid && !stall) begin
            valid_d[0] = 1'b1;
            a3_d[0]    = bus.d_a3;
            tnew_d[0]  = tnew_dec(bus.d_tnew);
            md_d       = bus.d_md_start;
        end
        if (bus.flush) begin
            valid_d = '0;
            a3_d    = '0;
            tnew_d  = '0;
            md_d    = 1'b0;
        end
        cnt_d = (stall && !bus.flush) ? cnt_sat_inc(cnt_q) : cnt_q;
    end

    // Slot and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            a3_q    <= '0;
            tnew_q  <= '0;
            md_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            a3_q    <= a3_d;
            tnew_q  <= tnew_d;
            md_q    <= md_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.stall      = stall;
    assign bus.fwd_sel_rs = hit_rs && (tnew_rs == '0) ? fwd_rs : '0;
    assign bus.fwd_sel_rt = hit_rt && (tnew_rt == '0) ? fwd_rt : '0;
    assign bus.stage_a3   = a3_q;
    assign bus.stage_tnew = tnew_q;
    assign bus.stall_cnt  = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Bench for hazard_ctrl_pipe: instruction-list model with per-cycle compare
// plus directed scenarios with hand-computed literal expectations.
module tb_hazard_ctrl_pipe;
    localparam int STAGES = 3;
    localparam int RW     = 5;
    localparam int TW     = 2;
    localparam int FW     = 2;
    localparam int CW     = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset;
    bit   chk_en = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl_pipe_if #(.STAGES(STAGES), .RW(RW), .TW(TW), .FW(FW), .CW(CW)) bus ();

    hazard_ctrl_pipe #(.STAGES(STAGES), .RW(RW), .TW(TW), .FW(FW), .CW(CW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // In-flight instruction list, youngest first; age 0 sits in slot 0.
    typedef struct {
        int a3;
        int tnew0;
        bit md;
        int age;
    } ins_t;
    ins_t q[$];
    int   m_cnt = 0;

    function automatic void check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endfunction

    function automatic int ins_tnew(int i);
        int tn;
        tn = q[i].tnew0 - 1 - q[i].age;
        return (tn < 0) ? 0 : tn;
    endfunction

    function automatic void m_operand(int r, bit rd, int tuse, output bit st, output int fw);
        st = 1'b0;
        fw = 0;
        if (!rd || r == 0) return;
        for (int i = 0; i < q.size(); i++) begin
            if (q[i].a3 == r) begin
                st = bus.d_valid && (ins_tnew(i) > tuse);
                fw = (ins_tnew(i) == 0) ? q[i].age + 1 : 0;
                return;
            end
        end
    endfunction

    function automatic void m_outputs(output bit st, output int frs, output int frt);
        bit s1, s2, smd;
        m_operand(int'(bus.d_rs), bus.d_read_rs, int'(bus.d_tuse_rs), s1, frs);
        m_operand(int'(bus.d_rt), bus.d_read_rt, int'(bus.d_tuse_rt), s2, frt);
        smd = bus.d_valid && bus.d_is_mdft &&
              (bus.mdu_busy || (q.size() > 0 && q[0].age == 0 && q[0].md));
        st = s1 || s2 || smd;
    endfunction

    function automatic void m_slot(int k, output int a3, output int tn);
        a3 = 0;
        tn = 0;
        for (int i = 0; i < q.size(); i++)
            if (q[i].age == k) begin
                a3 = q[i].a3;
                tn = ins_tnew(i);
            end
    endfunction

    // Model advance on each clock edge, using the values presented before it.
    always @(posedge clk) begin
        bit s;
        int f1, f2;
        m_outputs(s, f1, f2);
        if (reset) begin
            q.delete();
            m_cnt = 0;
        end else begin
            if (s && !bus.flush && m_cnt < CNT_MAX) m_cnt++;
            if (bus.flush) begin
                q.delete();
            end else begin
                foreach (q[i]) q[i].age++;
                while (q.size() > 0 && q[q.size()-1].age >= STAGES) void'(q.pop_back());
                if (bus.d_valid && !s)
                    q.push_front('{a3: int'(bus.d_a3), tnew0: int'(bus.d_tnew),
                                   md: bus.d_md_start, age: 0});
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        bit s;
        int frs, frt, ea3, etn;
        if (chk_en) begin
            m_outputs(s, frs, frt);
            check("m_stall", int'(bus.stall), int'(s));
            check("m_fwd_rs", int'(bus.fwd_sel_rs), frs);
            check("m_fwd_rt", int'(bus.fwd_sel_rt), frt);
            check("m_cnt", int'(bus.stall_cnt), m_cnt);
            for (int k = 0; k < STAGES; k++) begin
                m_slot(k, ea3, etn);
                check("m_stage_a3", int'(bus.stage_a3[k*RW +: RW]), ea3);
                check("m_stage_tnew", int'(bus.stage_tnew[k*TW +: TW]), etn);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bus.d_valid = 0; bus.d_rs = '0; bus.d_rt = '0; bus.d_read_rs = 0; bus.d_read_rt = 0;
        bus.d_tuse_rs = '0; bus.d_tuse_rt = '0; bus.d_a3 = '0; bus.d_tnew = '0;
        bus.d_is_mdft = 0; bus.d_md_start = 0; bus.mdu_busy = 0; bus.flush = 0;
    endtask

    task automatic set_d(int rs, bit rrs, int tus, int rt, bit rrt, int tut,
                         int a3, int tn, bit mdft, bit mst);
        bus.d_valid   = 1'b1;
        bus.d_rs      = RW'(rs);
        bus.d_read_rs = rrs;
        bus.d_tuse_rs = TW'(tus);
        bus.d_rt      = RW'(rt);
        bus.d_read_rt = rrt;
        bus.d_tuse_rt = TW'(tut);
        bus.d_a3      = RW'(a3);
        bus.d_tnew    = TW'(tn);
        bus.d_is_mdft = mdft;
        bus.d_md_start = mst;
    endtask

    initial begin
        clr();
        reset = 1'b1;
        tick();
        // Reset state: only the MDU busy term can stall.
        chk_en = 1'b1;
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        bus.mdu_busy = 1'b1;
        #1;
        check("rst_stall_md", int'(bus.stall), 1);
        check("rst_cnt", int'(bus.stall_cnt), 0);
        check("rst_a3", int'(bus.stage_a3), 0);
        check("rst_fwd", int'(bus.fwd_sel_rs), 0);
        tick();
        reset = 1'b0;
        clr();
        #1;
        check("rst_cnt_hold", int'(bus.stall_cnt), 0);
        tick();

        // Load-use: lw $1 then a D-stage reader of $1.
        set_d(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
        #1; check("lu_lw_stall", int'(bus.stall), 0);
        tick();
        set_d(1, 1, 0, 0, 0, 0, 4, 2, 0, 0);
        #1; check("lu_stall1", int'(bus.stall), 1);
        check("lu_s0_tnew", int'(bus.stage_tnew[0 +: TW]), 2);
        check("lu_s0_a3", int'(bus.stage_a3[0 +: RW]), 1);
        tick();
        #1; check("lu_stall2", int'(bus.stall), 1);
        check("lu_s1_tnew", int'(bus.stage_tnew[TW +: TW]), 1);
        tick();
        #1; check("lu_release", int'(bus.stall), 0);
        check("lu_fwd", int'(bus.fwd_sel_rs), 3);
        check("lu_cnt", int'(bus.stall_cnt), 2);
        tick();

        // Branch after ALU.
        set_d(0, 0, 0, 0, 0, 0, 2, 2, 0, 0);
        tick();
        set_d(2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; check("br_stall", int'(bus.stall), 1);
        tick();
        #1; check("br_release", int'(bus.stall), 0);
        check("br_fwd", int'(bus.fwd_sel_rs), 2);
        tick();

        // jal / jr $31.
        set_d(0, 0, 0, 0, 0, 0, 31, 1, 0, 0);
        tick();
        set_d(31, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; check("jr_stall", int'(bus.stall), 0);
        check("jr_fwd", int'(bus.fwd_sel_rs), 1);
        tick();

        // Writer of $0 is never a hazard.
        set_d(0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
        tick();
        set_d(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
        #1; check("r0_stall", int'(bus.stall), 0);
        check("r0_fwd_rs", int'(bus.fwd_sel_rs), 0);
        check("r0_fwd_rt", int'(bus.fwd_sel_rt), 0);
        tick();

        // Two writers of $3: youngest wins.
        set_d(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 3, 1, 0, 0);
        tick();
        set_d(0, 0, 0, 3, 1, 0, 0, 0, 0, 0);
        #1; check("pri_stall", int'(bus.stall), 0);
        check("pri_fwd_rt", int'(bus.fwd_sel_rt), 1);
        tick();

        // Counter saturation under a long MDU stall.
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        bus.mdu_busy = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        #1; check("sat_cnt", int'(bus.stall_cnt), CNT_MAX);

        // Reset while stalled.
        clr();
        set_d(0, 0, 0, 0, 0, 0, 10, 3, 0, 0);
        tick();
        set_d(10, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1; check("rms_stall", int'(bus.stall), 1);
        tick();
        reset = 1'b0;
        clr();
        #1; check("rms_cnt", int'(bus.stall_cnt), 0);
        check("rms_a3", int'(bus.stage_a3), 0);
        check("rms_stall_after", int'(bus.stall), 0);
        tick();

        // MDU: mult then mflo, then busy for 5 cycles.
        set_d(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        #1; check("md_mult", int'(bus.stall), 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 5, 2, 1, 0);
        #1; check("md_slot0", int'(bus.stall), 1);
        tick();
        bus.mdu_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1; check("md_busy", int'(bus.stall), 1);
            tick();
        end
        bus.mdu_busy = 1'b0;
        #1; check("md_release", int'(bus.stall), 0);
        check("md_cnt", int'(bus.stall_cnt), 6);
        tick();

        // Flush with a simultaneous stall.
        set_d(0, 0, 0, 0, 0, 0, 7, 3, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 8, 3, 0, 0);
        tick();
        set_d(0, 0, 0, 0, 0, 0, 9, 3, 0, 0);
        tick();
        set_d(9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.flush = 1'b1;
        #1; check("fl_stall", int'(bus.stall), 1);
        check("fl_s2_a3", int'(bus.stage_a3[2*RW +: RW]), 7);
        tick();
        clr();
        #1; check("fl_a3", int'(bus.stage_a3), 0);
        check("fl_stall_after", int'(bus.stall), 0);
        check("fl_cnt", int'(bus.stall_cnt), 6);
        tick();
        tick();

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
